// File: rtl/car_parking_system.sv
// Car park entrance gate controller.
// A car at the front sensor is asked for a 4-digit password. A correct
// password opens the gate (green LED blinking). The back sensor confirms
// the car went through, which bumps the parked-car count. A wrong password
// blinks the red LED until the right one is keyed in. A second car already
// waiting when the first one passes is held in STOP (red blinking) until
// the back sensor clears.
//
// All outputs are registered. The LED pattern and count for a transition
// appear on the same edge that registers the new state.
//
// The FSM state is held in the signal 'state' (type state_t) so that a
// checker can observe it hierarchically without extra ports.
module car_parking_system #(
   parameter logic [3:0]  PASS4       = 4'd1,
   parameter logic [3:0]  PASS3       = 4'd2,
   parameter logic [3:0]  PASS2       = 4'd3,
   parameter logic [3:0]  PASS1       = 4'd4,
   parameter int unsigned WAIT_CYCLES = 3,
   parameter int unsigned CAPACITY    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Fs,
   input  logic       Bs,
   input  logic [3:0] P4,
   input  logic [3:0] P3,
   input  logic [3:0] P2,
   input  logic [3:0] P1,
   output logic       gLED,
   output logic       rLED,
   output logic [3:0] carCount
);

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      WAIT_PASSWORD = 3'd1,
      WRONG_PASS    = 3'd2,
      RIGHT_PASS    = 3'd3,
      STOP          = 3'd4
   } state_t;

   // Counter value on which the password is checked, and the full level.
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0] CAP       = 4'(CAPACITY);

   state_t     state;
   state_t     state_n;
   logic [3:0] wait_cnt;
   logic [3:0] wait_cnt_n;
   logic       blink;
   logic       blink_n;
   logic [3:0] car_count_n;
   logic       gled_n;
   logic       rled_n;
   logic       match;
   logic       full;
   logic       next_blinks;

   // Password compare on the live keypad inputs; digits above 9 simply miss.
   assign match = (P4 == PASS4) && (P3 == PASS3) &&
                  (P2 == PASS2) && (P1 == PASS1);

   assign full = (carCount == CAP);

   // Next-state, counters, blink phase and registered output values.
   always_comb begin
      state_n     = state;
      wait_cnt_n  = wait_cnt;
      car_count_n = carCount;
      blink_n     = 1'b0;
      gled_n      = 1'b0;
      rled_n      = 1'b0;
      next_blinks = 1'b0;

      case (state)
         IDLE: begin
            // Back sensor is ignored here; a full park keeps the car out.
            if (Fs && !full) begin
               state_n    = WAIT_PASSWORD;
               wait_cnt_n = 4'd0;
            end
         end
         WAIT_PASSWORD: begin
            // Front sensor is ignored while the driver types.
            wait_cnt_n = wait_cnt + 4'd1;
            if (wait_cnt == WAIT_LAST) begin
               state_n = match ? RIGHT_PASS : WRONG_PASS;
            end
         end
         WRONG_PASS: begin
            if (match) begin
               state_n = RIGHT_PASS;
            end
         end
         RIGHT_PASS: begin
            // Car went through: count it, then either idle or hold the
            // car that is already waiting behind it.
            if (Bs) begin
               state_n = Fs ? STOP : IDLE;
               if (!full) begin
                  car_count_n = carCount + 4'd1;
               end
            end
         end
         STOP: begin
            // The keypad still holds the previous driver's digits, so a
            // match here is accepted as soon as the back sensor clears.
            if (!Bs && match) begin
               state_n = RIGHT_PASS;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Blink starts high on entry to a blinking state, then toggles.
      next_blinks = (state_n == WRONG_PASS) || (state_n == RIGHT_PASS) ||
                    (state_n == STOP);
      if (next_blinks) begin
         blink_n = (state_n != state) ? 1'b1 : ~blink;
      end

      case (state_n)
         IDLE:          rled_n = (car_count_n == CAP);
         WAIT_PASSWORD: rled_n = 1'b1;
         WRONG_PASS:    rled_n = blink_n;
         STOP:          rled_n = blink_n;
         RIGHT_PASS:    gled_n = blink_n;
         default: begin
            gled_n = 1'b0;
            rled_n = 1'b0;
         end
      endcase
   end

   // State, counters and outputs register; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         blink    <= 1'b0;
         gLED     <= 1'b0;
         rLED     <= 1'b0;
         carCount <= 4'd0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         blink    <= blink_n;
         gLED     <= gled_n;
         rLED     <= rled_n;
         carCount <= car_count_n;
      end
   end

endmodule

// File: tb/tb_car_parking_system.sv
// Directed bench for car_parking_system. Each stimulus step pushes the
// hand-computed response expected after the next rising edge; a monitor
// pops and compares one entry per edge.
module tb_car_parking_system;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_WRONG = 3'd2;
   localparam logic [2:0] S_RIGHT = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   localparam logic [15:0] GOOD = 16'h1234;
   localparam logic [15:0] BAD  = 16'h0204;
   localparam int          W    = 9;   // {state, gLED, rLED, carCount}

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       Fs = 1'b0;
   logic       Bs = 1'b0;
   logic [3:0] P4 = 4'd0;
   logic [3:0] P3 = 4'd0;
   logic [3:0] P2 = 4'd0;
   logic [3:0] P1 = 4'd0;
   logic       gLED;
   logic       rLED;
   logic [3:0] carCount;

   always #5 clk = ~clk;

   car_parking_system dut (
      .clk      (clk),
      .reset    (reset),
      .Fs       (Fs),
      .Bs       (Bs),
      .P4       (P4),
      .P3       (P3),
      .P2       (P2),
      .P1       (P1),
      .gLED     (gLED),
      .rLED     (rLED),
      .carCount (carCount)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           vectors = 0;
   int           miscompares = 0;
   int           model_cnt = 0;

   initial begin : monitor
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      string        nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {3'(dut.state), gLED, rLED, carCount};
            vectors++;
            if (act_v !== exp_v) begin
               miscompares++;
               $display("FAIL %s: got st=%0d g=%b r=%b cnt=%0d, expected st=%0d g=%b r=%b cnt=%0d",
                        nm, act_v[8:6], act_v[5], act_v[4], act_v[3:0],
                        exp_v[8:6], exp_v[5], exp_v[4], exp_v[3:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic rst, input logic fs, input logic bs,
                       input logic [15:0] p, input logic [2:0] est,
                       input logic eg, input logic er, input logic [3:0] ecnt,
                       input string nm);
      @(negedge clk);
      reset = rst;
      Fs    = fs;
      Bs    = bs;
      {P4, P3, P2, P1} = p;
      exp_q.push_back({est, eg, er, ecnt});
      name_q.push_back(nm);
   endtask

   task automatic reset_step(input string nm);
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 65535)), S_IDLE, 1'b0, 1'b0, 4'd0, nm);
      model_cnt = 0;
   endtask

   // One car from IDLE through to IDLE again; model_cnt must be below 8.
   task automatic park(input bit wrong_first, input int bs_hold);
      logic [15:0] p0;
      p0 = wrong_first ? BAD : GOOD;
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, p0, S_WAIT, 1'b0, 1'b1, 4'(model_cnt), "park_wait");
      if (wrong_first) begin
         step(1'b0, 1'b1, 1'b0, BAD,  S_WRONG, 1'b0, 1'b1, 4'(model_cnt), "park_wrong1");
         step(1'b0, 1'b1, 1'b0, BAD,  S_WRONG, 1'b0, 1'b0, 4'(model_cnt), "park_wrong0");
         step(1'b0, 1'b1, 1'b0, GOOD, S_RIGHT, 1'b1, 1'b0, 4'(model_cnt), "park_fix");
      end else begin
         step(1'b0, 1'b1, 1'b0, GOOD, S_RIGHT, 1'b1, 1'b0, 4'(model_cnt), "park_right");
      end
      step(1'b0, 1'b0, 1'b0, GOOD, S_RIGHT, 1'b0, 1'b0, 4'(model_cnt), "park_blink");
      model_cnt++;
      step(1'b0, 1'b0, 1'b1, GOOD, S_IDLE, 1'b0, 1'(model_cnt == 8), 4'(model_cnt), "park_pass");
      for (int i = 0; i < bs_hold; i++)
         step(1'b0, 1'b0, 1'b1, GOOD, S_IDLE, 1'b0, 1'(model_cnt == 8), 4'(model_cnt), "bs_held_idle");
   endtask

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int guard;

      // Reset with random inputs.
      reset_step("reset0");
      reset_step("reset1");

      // Correct entry.
      step(1'b0, 1'b1, 1'b0, GOOD, S_WAIT,  1'b0, 1'b1, 4'd0, "entry_wait0");
      step(1'b0, 1'b1, 1'b0, GOOD, S_WAIT,  1'b0, 1'b1, 4'd0, "entry_wait1");
      step(1'b0, 1'b1, 1'b0, GOOD, S_WAIT,  1'b0, 1'b1, 4'd0, "entry_wait2");
      step(1'b0, 1'b0, 1'b0, GOOD, S_RIGHT, 1'b1, 1'b0, 4'd0, "entry_right");
      step(1'b0, 1'b0, 1'b0, GOOD, S_RIGHT, 1'b0, 1'b0, 4'd0, "entry_blink0");
      step(1'b0, 1'b0, 1'b0, GOOD, S_RIGHT, 1'b1, 1'b0, 4'd0, "entry_blink1");
      step(1'b0, 1'b0, 1'b1, GOOD, S_IDLE,  1'b0, 1'b0, 4'd1, "entry_pass");

      // Wrong then right.
      step(1'b0, 1'b1, 1'b0, BAD,  S_WAIT,  1'b0, 1'b1, 4'd1, "wrong_wait0");
      step(1'b0, 1'b1, 1'b0, BAD,  S_WAIT,  1'b0, 1'b1, 4'd1, "wrong_wait1");
      step(1'b0, 1'b1, 1'b0, BAD,  S_WAIT,  1'b0, 1'b1, 4'd1, "wrong_wait2");
      step(1'b0, 1'b1, 1'b0, BAD,  S_WRONG, 1'b0, 1'b1, 4'd1, "wrong_enter");
      step(1'b0, 1'b1, 1'b0, BAD,  S_WRONG, 1'b0, 1'b0, 4'd1, "wrong_blink0");
      step(1'b0, 1'b1, 1'b0, 16'hA2F4, S_WRONG, 1'b0, 1'b1, 4'd1, "wrong_digit_gt9");
      step(1'b0, 1'b1, 1'b0, GOOD, S_RIGHT, 1'b1, 1'b0, 4'd1, "wrong_to_right");
      step(1'b0, 1'b1, 1'b0, GOOD, S_RIGHT, 1'b0, 1'b0, 4'd1, "right_hold");

      // Tailgate: next car waiting when the first one passes.
      step(1'b0, 1'b1, 1'b1, GOOD, S_STOP,  1'b0, 1'b1, 4'd2, "tail_stop");
      step(1'b0, 1'b1, 1'b1, GOOD, S_STOP,  1'b0, 1'b0, 4'd2, "tail_bs_high");
      step(1'b0, 1'b1, 1'b0, BAD,  S_STOP,  1'b0, 1'b1, 4'd2, "tail_bad_pass");
      step(1'b0, 1'b1, 1'b0, GOOD, S_RIGHT, 1'b1, 1'b0, 4'd2, "tail_to_right");
      step(1'b0, 1'b0, 1'b1, GOOD, S_IDLE,  1'b0, 1'b0, 4'd3, "tail_pass");

      // Reset aborts RIGHT_PASS.
      step(1'b0, 1'b1, 1'b0, GOOD, S_WAIT,  1'b0, 1'b1, 4'd3, "rr_wait0");
      step(1'b0, 1'b1, 1'b0, GOOD, S_WAIT,  1'b0, 1'b1, 4'd3, "rr_wait1");
      step(1'b0, 1'b1, 1'b0, GOOD, S_WAIT,  1'b0, 1'b1, 4'd3, "rr_wait2");
      step(1'b0, 1'b1, 1'b0, GOOD, S_RIGHT, 1'b1, 1'b0, 4'd3, "rr_right");
      reset_step("reset_in_right");

      // Four cars, alternating passwords, Bs held in IDLE afterwards.
      park(1'b0, 2);
      park(1'b1, 2);
      park(1'b0, 0);
      park(1'b1, 3);

      // Fill up to capacity.
      park(1'b0, 0);
      park(1'b1, 0);
      park(1'b0, 1);
      park(1'b0, 0);

      // Full: arriving car is refused, count saturates.
      step(1'b0, 1'b1, 1'b0, GOOD, S_IDLE, 1'b0, 1'b1, 4'd8, "full_refuse0");
      step(1'b0, 1'b1, 1'b0, GOOD, S_IDLE, 1'b0, 1'b1, 4'd8, "full_refuse1");
      step(1'b0, 1'b1, 1'b1, GOOD, S_IDLE, 1'b0, 1'b1, 4'd8, "full_fs_bs");
      step(1'b0, 1'b1, 1'b0, GOOD, S_IDLE, 1'b0, 1'b1, 4'd8, "full_refuse2");
      reset_step("reset_when_full");

      // Let the monitor drain the queue, bounded.
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
